// File: rtl/fpu_ieee_packer.sv
// Converts FPU results (6-bit exponent, bias 31, 25-bit mantissa) into IEEE-754 single precision
// through a 2-stage valid/ready pipeline. Optional inexact counter is enabled by FPU_PACK_INEXACT_CNT_EN.
module fpu_ieee_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] data_in,
   input  logic [3:0]  status_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] ieee_out,
   output logic [3:0]  fpu_status_out,
   output logic [3:0]  flags_out
`ifdef FPU_PACK_INEXACT_CNT_EN
   ,
   output logic [15:0] inexact_count
`endif
);

   localparam logic [3:0] FLAG_NAN     = 4'b1000;
   localparam logic [3:0] FLAG_INF     = 4'b0100;
   localparam logic [3:0] FLAG_ZERO    = 4'b0010;
   localparam logic [3:0] FLAG_INEXACT = 4'b0001;

   logic        s2_adv;
   logic        s1_adv;

   logic        s1_valid_q, s1_valid_d;
   logic        s1_sign_q, s1_sign_d;
   logic [7:0]  s1_exp_q, s1_exp_d;
   logic [22:0] s1_frac_q, s1_frac_d;
   logic [3:0]  s1_flags_q, s1_flags_d;
   logic [3:0]  s1_status_q, s1_status_d;

   logic        out_valid_q, out_valid_d;
   logic [31:0] ieee_q, ieee_d;
   logic [3:0]  status_q, status_d;
   logic [3:0]  flags_q, flags_d;

   logic [5:0]  in_exp;
   logic [24:0] in_mant;
   logic        round_up;
   logic [23:0] frac_rnd;
   logic [7:0]  exp_norm;

`ifdef FPU_PACK_INEXACT_CNT_EN
   logic [15:0] cnt_q, cnt_d;
`endif

   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = !s1_valid_q || s1_adv;

      in_exp   = data_in[30:25];
      in_mant  = data_in[24:0];
      // Round to nearest even: guard is mant[1], sticky is mant[0], lsb of the kept fraction is mant[2].
      round_up = in_mant[1] && (in_mant[0] || in_mant[2]);
      frac_rnd = {1'b0, in_mant[24:2]} + {23'b0, round_up};
      // Largest finite input exponent is 62, so 62+96+carry tops out at 159.
      exp_norm = {2'b00, in_exp} + 8'd96 + {7'b0, frac_rnd[23]};

      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_frac_d   = s1_frac_q;
      s1_flags_d  = s1_flags_q;
      s1_status_d = s1_status_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_status_d = status_in;
            s1_sign_d   = data_in[31];
            if (in_exp == 6'd0) begin
               s1_exp_d   = 8'h00;
               s1_frac_d  = 23'b0;
               s1_flags_d = FLAG_ZERO;
            end else if (in_exp == 6'd63) begin
               s1_exp_d = 8'hFF;
               if (in_mant == 25'b0) begin
                  s1_frac_d  = 23'b0;
                  s1_flags_d = FLAG_INF;
               end else begin
                  s1_sign_d  = 1'b0;
                  s1_frac_d  = 23'h400000;
                  s1_flags_d = FLAG_NAN;
               end
            end else begin
               s1_exp_d   = exp_norm;
               s1_frac_d  = frac_rnd[22:0];
               s1_flags_d = (in_mant[1:0] != 2'b00) ? FLAG_INEXACT : 4'b0000;
            end
         end
      end

      out_valid_d = out_valid_q;
      ieee_d      = ieee_q;
      status_d    = status_q;
      flags_d     = flags_q;

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            ieee_d   = {s1_sign_q, s1_exp_q, s1_frac_q};
            status_d = s1_status_q;
            flags_d  = s1_flags_q;
         end
      end

`ifdef FPU_PACK_INEXACT_CNT_EN
      cnt_d = cnt_q;
      if (out_valid_q && out_ready && flags_q[0] && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= 8'h00;
         s1_frac_q   <= 23'b0;
         s1_flags_q  <= 4'b0;
         s1_status_q <= 4'b0;
         out_valid_q <= 1'b0;
         ieee_q      <= 32'b0;
         status_q    <= 4'b0;
         flags_q     <= 4'b0;
`ifdef FPU_PACK_INEXACT_CNT_EN
         cnt_q       <= 16'h0000;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_frac_q   <= s1_frac_d;
         s1_flags_q  <= s1_flags_d;
         s1_status_q <= s1_status_d;
         out_valid_q <= out_valid_d;
         ieee_q      <= ieee_d;
         status_q    <= status_d;
         flags_q     <= flags_d;
`ifdef FPU_PACK_INEXACT_CNT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign out_valid      = out_valid_q;
   assign ieee_out       = ieee_q;
   assign fpu_status_out = status_q;
   assign flags_out      = flags_q;
`ifdef FPU_PACK_INEXACT_CNT_EN
   assign inexact_count  = cnt_q;
`endif

endmodule
